// File: rtl/egress_arbiter.sv
// Egress arbiter for one output port. It selects frames addressed to PORT_ID
// from the ingress filter streams, serves the sources round-robin, and holds
// the grant until the whole frame has passed. Output is one registered
// AXI-Stream stage.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no frame locked; arbitrate among requesting sources
// LOCKED | source gnt owns the output until its tlast beat is accepted
module egress_arbiter #(
  parameter int         NUM_INGRESS = 4,
  parameter logic [1:0] PORT_ID     = 2'd0,
  parameter int         DATA_WIDTH  = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              en,
  input  logic [NUM_INGRESS-1:0]            in_tvalid,
  input  logic [NUM_INGRESS*DATA_WIDTH-1:0] in_tdata,
  input  logic [NUM_INGRESS*2-1:0]          in_tdest,
  input  logic [NUM_INGRESS-1:0]            in_tlast,
  output logic [NUM_INGRESS-1:0]            in_tready,
  output logic                              out_tvalid,
  output logic [DATA_WIDTH-1:0]             out_tdata,
  output logic [1:0]                        out_tdest,
  output logic                              out_tlast,
  input  logic                              out_tready,
  output logic                              busy,
  output logic [15:0]                       frames_out
);

  localparam int IW = $clog2(NUM_INGRESS);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t                 state;
  logic [IW-1:0]          rr_ptr;
  logic [IW-1:0]          gnt;
  logic [IW-1:0]          pick;
  logic [IW-1:0]          gnt_next_ptr;
  logic [NUM_INGRESS-1:0] req;
  logic                   any_req;
  logic [DATA_WIDTH-1:0]  gnt_data;
  logic                   gnt_valid;
  logic                   gnt_last;
  logic                   gnt_ready;
  logic                   accept;

  // A source requests when enabled, valid, and its current beat targets this port.
  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_INGRESS; i++) begin
      req[i] = en & in_tvalid[i] & (in_tdest[i*2 +: 2] == PORT_ID);
    end
  end

  assign any_req = |req;

  // Round-robin pick: first requester at or above rr_ptr, wrapping. The loop
  // runs downward so the smallest offset is the last (winning) assignment.
  always_comb begin
    int idx;
    idx  = 0;
    pick = rr_ptr;
    for (int k = NUM_INGRESS - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_INGRESS;
      if (req[idx]) pick = IW'(idx);
    end
  end

  // Granted-source mux and handshake; ready opens when the output stage can take a beat.
  always_comb begin
    gnt_valid = in_tvalid[gnt];
    gnt_last  = in_tlast[gnt];
    gnt_data  = in_tdata[int'(gnt)*DATA_WIDTH +: DATA_WIDTH];
    gnt_ready = ~out_tvalid | out_tready;
    in_tready = '0;
    if (state == LOCKED) in_tready[gnt] = gnt_ready;
  end

  assign accept       = (state == LOCKED) & gnt_valid & gnt_ready;
  assign gnt_next_ptr = (gnt == IW'(NUM_INGRESS - 1)) ? '0 : gnt + IW'(1);
  assign busy         = (state == LOCKED);
  assign out_tdest    = PORT_ID;

  // Arbitration FSM: lock a source at grant, release after its tlast beat is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      gnt    <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt   <= pick;
            state <= LOCKED;
          end
        end
        LOCKED: begin
          if (accept && gnt_last) begin
            rr_ptr <= gnt_next_ptr;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output stage: load on accept (also replaces a beat draining this cycle), clear on drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_tvalid <= 1'b0;
      out_tdata  <= '0;
      out_tlast  <= 1'b0;
    end else if (accept) begin
      out_tvalid <= 1'b1;
      out_tdata  <= gnt_data;
      out_tlast  <= gnt_last;
    end else if (out_tvalid && out_tready) begin
      out_tvalid <= 1'b0;
      out_tdata  <= '0;
      out_tlast  <= 1'b0;
    end
  end

  // Completed-frame counter, free-running with natural wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      frames_out <= '0;
    end else if (out_tvalid && out_tready && out_tlast) begin
      frames_out <= frames_out + 16'd1;
    end
  end

endmodule
